// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide sequencer that owns the
// architectural HI/LO pair. It runs a WIDTH-step shift-add multiply or
// restoring divide on unsigned magnitudes. A final FIX cycle applies the
// signs and commits HI/LO. MTHI/MTLO and divide-by-zero results are
// written directly from IDLE.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t state, next_state;

    // Working registers. opnd holds the multiplicand (MUL) or the divisor (DIV).
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;     // {partial product, remaining multiplier bits}
    logic [WIDTH-1:0]   rem;     // partial remainder
    logic [WIDTH-1:0]   quo;     // dividend bits shifting out, quotient bits shifting in
    logic               neg_q;
    logic               neg_r;
    logic               is_div;

    // Operand decode
    logic             is_mul_op;
    logic             is_div_op;
    logic             is_signed;
    logic             divisor_zero;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign is_mul_op    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op    = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_signed    = (op == OP_MULT) || (op == OP_DIV);
    assign divisor_zero = (op_b == '0);
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign abs_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign abs_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    assign busy = (state != S_IDLE);

    // One multiply step and one restoring-divide step, computed from current state
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        div_shift = {rem, quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        // Bit WIDTH of the difference is set exactly when the trial subtraction
        // underflows, because the shifted remainder is always below 2*divisor.
        if (!div_diff[WIDTH]) begin
            rem_next = div_diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = div_shift[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        // NOTE: next_state is defaulted first so no path through the case leaves
        // it unassigned, which would infer a latch.
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (start && is_mul_op)                      next_state = S_MUL;
                else if (start && is_div_op && !divisor_zero) next_state = S_DIV;
            end
            S_MUL:   if (cnt == LAST) next_state = S_FIX;
            S_DIV:   if (cnt == LAST) next_state = S_FIX;
            S_FIX:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, commit of HI/LO, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every working register is reset too, so an aborted sequence
        // leaves no stale operands or sign flags behind.
        if (!rst_n) begin
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
            rem    <= '0;
            quo    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi <= op_a;
                        end else if (op == OP_MTLO) begin
                            lo <= op_a;
                        end else if (is_mul_op) begin
                            opnd   <= abs_a;
                            acc    <= {{WIDTH{1'b0}}, abs_b};
                            neg_q  <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            neg_r  <= is_signed && op_a[WIDTH-1];
                            is_div <= 1'b0;
                            cnt    <= '0;
                        end else if (is_div_op && divisor_zero) begin
                            lo   <= '1;
                            hi   <= op_a;
                            done <= 1'b1;
                        end else if (is_div_op) begin
                            opnd   <= abs_b;
                            quo    <= abs_a;
                            rem    <= '0;
                            neg_q  <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            neg_r  <= is_signed && op_a[WIDTH-1];
                            is_div <= 1'b1;
                            cnt    <= '0;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + CNT_W'(1);
                end
                S_DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (is_div) begin
                        lo <= neg_q ? -quo : quo;
                        hi <= neg_r ? -rem : rem;
                    end else begin
                        {hi, lo} <= neg_q ? -acc : acc;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed testbench for hilo_muldiv_unit. Inputs are driven and outputs
// sampled on the falling clock edge, away from the active rising edge.
module tb_hilo_muldiv_unit;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;
    localparam logic [2:0] NOP   = 3'b110;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Caller is at a falling edge; the next rising edge samples the request.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        op    = NOP;
    endtask

    // Counts falling edges while busy, bounded so a stuck DUT cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        op    = NOP;
        op_a  = '0;
        op_b  = '0;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu();
        int n;
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL multu_busy_after_e0: got %b expected 1", busy); end
        wait_idle(n);
        checks++; if (n != 33) begin failures++; $display("FAIL multu_busy_cycles: got %0d expected 33", n); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL multu_done: got %b expected 1", done); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_mult();
        int n;
        issue(MULT, 32'h8000_0000, 32'h8000_0000);
        wait_idle(n);
        checks++; if (n != 33) begin failures++; $display("FAIL mult_min_cycles: got %0d expected 33", n); end
        checks++; if (hi !== 32'h4000_0000) begin failures++; $display("FAIL mult_min_hi: got %h expected 40000000", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL mult_min_lo: got %h expected 00000000", lo); end
        @(negedge clk);
    endtask

    task automatic test_div();
        int n;
        issue(DIV, 32'hFFFF_FFF9, 32'd2);              // -7 / 2
        wait_idle(n);
        checks++; if (n != 33) begin failures++; $display("FAIL div_neg_cycles: got %0d expected 33", n); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL div_neg_done: got %b expected 1", done); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
        @(negedge clk);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);      // overflow case
        wait_idle(n);
        checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi); end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        issue(DIVU, 32'd7, 32'd0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL divz_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL divz_done: got %b expected 1", done); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divz_lo: got %h expected ffffffff", lo); end
        checks++; if (hi !== 32'd7) begin failures++; $display("FAIL divz_hi: got %h expected 00000007", hi); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL divz_done_clear: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL divz_busy_later: got %b expected 0", busy); end
        issue(DIV, 32'hFFFF_FFF9, 32'd0);              // signed: hi gets raw dividend
        checks++; if (hi !== 32'hFFFF_FFF9) begin failures++; $display("FAIL divz_signed_hi: got %h expected fffffff9", hi); end
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1;
        op    = MTHI;
        op_a  = 32'h1234_5678;
        @(negedge clk);
        checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mthi_done: got %b expected 0", done); end
        op   = MTLO;
        op_a = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        op    = NOP;
        checks++; if (lo !== 32'hCAFE_F00D) begin failures++; $display("FAIL mtlo_lo: got %h expected cafef00d", lo); end
        checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mtlo_hi_kept: got %h expected 12345678", hi); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mtlo_done: got %b expected 0", done); end
    endtask

    // Follows test_mthi_mtlo so HI/LO hold known values during the sequence.
    task automatic test_start_ignored();
        int n;
        issue(MULT, 32'hFFFF_FFFD, 32'd5);             // -3 * 5
        repeat (9) @(negedge clk);
        issue(MTHI, 32'hDEAD_BEEF, 32'd0);             // sampled at E10, must be ignored
        checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL busy_hold_hi: got %h expected 12345678", hi); end
        checks++; if (lo !== 32'hCAFE_F00D) begin failures++; $display("FAIL busy_hold_lo: got %h expected cafef00d", lo); end
        wait_idle(n);
        checks++; if (n != 23) begin failures++; $display("FAIL ignored_remaining_cycles: got %0d expected 23", n); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mult_neg_lo: got %h expected fffffff1", lo); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_no_requeue: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(MULTU, 32'd3, 32'd4);
        wait_idle(n);
        checks++; if (lo !== 32'd12) begin failures++; $display("FAIL b2b_first_lo: got %h expected 0000000c", lo); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_first_done: got %b expected 1", done); end
        issue(DIVU, 32'd100, 32'd7);                   // sampled on the done edge
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_clear: got %b expected 0", done); end
        wait_idle(n);
        checks++; if (n != 33) begin failures++; $display("FAIL b2b_second_cycles: got %0d expected 33", n); end
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL divu_lo: got %h expected 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL divu_hi: got %h expected 00000002", hi); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        issue(MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b expected 0", done); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL rstmid_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL rstmid_lo: got %h expected 00000000", lo); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(MULTU, 32'd6, 32'd7);
        wait_idle(n);
        checks++; if (lo !== 32'd42) begin failures++; $display("FAIL post_reset_lo: got %h expected 0000002a", lo); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL post_reset_hi: got %h expected 00000000", hi); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide sequencer with the architectural HI/LO register pair, executing MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside `alu_control`/ALU in EX. The decoder issues a one-cycle `start` pulse; the unit runs a 32-step shift-add or restoring-divide sequence and commits HI/LO. `busy` is the stall source for any MFHI/MFLO or new mul/div issued during a sequence.

## Interface
- `WIDTH`, 32: operand and HI/LO width; the iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  op request; sampled on `clk` edges only while the state is IDLE.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- `op_a`  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO data.
- `op_b`  in  WIDTH  rt value: multiplier or divisor.
- `busy`  out  1  high while the state is not IDLE; decoded from the state register only.
- `done`  out  1  one-cycle registered pulse when a mul/div commits HI/LO.
- `hi`  out  WIDTH  committed HI register.
- `lo`  out  WIDTH  committed LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- **Reset:** asserting `rst_n` low forces the following immediately, in any state:
  - state IDLE, `hi` = `lo` = 0, `busy` = 0, `done` = 0;
  - iteration counter and all working registers cleared;
  - any in-flight sequence is discarded with no commit.
- **IDLE, `start`=1:**
  - MTHI/MTLO: `hi`/`lo` ← `op_a` on that edge. No busy, no done.
  - MULT/MULTU: capture operands, go to MUL, counter ← 0.
  - DIV/DIVU with `op_b` ≠ 0: capture operands, go to DIV, counter ← 0.
  - DIV/DIVU with `op_b` = 0: on that edge `lo` ← all-ones and `hi` ← `op_a`; stay IDLE; `done` pulses next cycle.
  - Ops 110/111: ignored.
- **Signed ops (MULT, DIV):**
  - Capture the magnitudes of `op_a` and `op_b`; |−2^(WIDTH−1)| = 2^(WIDTH−1) as unsigned.
  - Record `neg_q` = sign(a) XOR sign(b) and `neg_r` = sign(a).
  - Unsigned ops clear both flags.
- **MUL:**
  - Each edge: if multiplier LSB = 1, add the multiplicand to the upper half of a 2·WIDTH accumulator, carry kept; then shift the accumulator/multiplier right by one.
  - After `WIDTH` steps, go to FIX.
- **DIV:**
  - Restoring division, one quotient bit per edge, `WIDTH+1`-bit partial remainder.
  - After `WIDTH` steps, go to FIX.
- **FIX (one cycle):**
  - MUL: negate the 2·WIDTH product if `neg_q`; `hi` ← upper half, `lo` ← lower half.
  - DIV: `lo` ← quotient, negated if `neg_q`; `hi` ← remainder, negated if `neg_r`.
  - Go to IDLE and set `done`.
- **Overflow:** −2^31 / −1 gives `lo` = 0x80000000, `hi` = 0, by natural truncation. No trap.
- **`start` while busy** is ignored entirely; no queueing. The decoder must hold the instruction while `busy` = 1.
- **Reads during a sequence:** `hi`/`lo` hold their previous committed values until the FIX edge. MFHI/MFLO must stall on `busy`.

## Timing
- Mul/div, counting from edge E0 (the edge that samples `start`):
  - `busy` = 1 after E0.
  - Iterations occur on E1..E32; E32 enters FIX.
  - E33 commits HI/LO, and then `busy` = 0 and `done` = 1 for exactly one cycle.
  - Total latency: 33 cycles from E0 to result valid.
- Divide-by-zero: result valid after E0, `done` high after E0, `busy` never asserted.
- MTHI/MTLO: result valid after E0.
- Back-to-back: a new `start` may be sampled on the edge where `done` = 1, because the state is IDLE.
- `done` clears on the following edge unless another divide-by-zero commit occurs on that edge.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 edges `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` pulses once, `busy` high exactly 33 cycles.
- MULT −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0.
- DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100 / 7 → `lo`=14, `hi`=2. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 7 / 0 → `lo`=0xFFFFFFFF, `hi`=7 one edge after start, `busy` never high.
- MTHI 0x12345678 then MTLO 0xCAFEF00D on consecutive edges → `hi`/`lo` update each next cycle. Then MULT with a `start` pulse at cycle 10 of the sequence → that pulse is ignored and the result equals the first op only.
- Start MULTU, drop `rst_n` at cycle 15 → `busy`, `done`, `hi`, `lo` go to 0 immediately. After release, a fresh MULTU 6 × 7 gives `lo`=42.
